// File: rtl/hazard5_fetch_responder.sv
// Fetch-side slave: accepts pipelined address phases from the core frontend and
// returns instruction words from an internal synchronous RAM. Wait states are
// programmable per transaction, and a backdoor port loads the program image.
module hazard5_fetch_responder #(
  parameter int unsigned W_ADDR    = 32,
  parameter int unsigned W_DATA    = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned W_WAIT    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_size,
  input  logic [W_ADDR-1:0]            mem_addr,
  input  logic                         mem_addr_vld,
  output logic                         mem_addr_rdy,
  output logic [W_DATA-1:0]            mem_data,
  output logic                         mem_data_vld,
  input  logic [W_WAIT-1:0]            wait_cfg,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
  input  logic [W_DATA-1:0]            ld_data,
  output logic [31:0]                  fetch_count,
  output logic                         busy
);

  localparam int unsigned W_IDX = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StLast
  } state_t;

  state_t              state_q, state_d;
  logic [W_WAIT-1:0]   wait_cnt_q, wait_cnt_d;
  logic [W_DATA-1:0]   word_q;
  logic [W_DATA-1:0]   mem [MEM_DEPTH];
  logic                accept;
  logic [W_IDX-1:0]    rd_idx;

  // Size, byte offset and bits above the RAM index do not affect the read:
  // halfword fetches return the whole aligned word and addresses wrap.
  logic unused_bits;
  assign unused_bits = ^{mem_size, mem_addr[1:0], mem_addr[W_ADDR-1:2+W_IDX]};

  assign accept = mem_addr_vld && mem_addr_rdy;
  assign rd_idx = mem_addr[2 +: W_IDX];

  // RAM: backdoor write plus read issued on the acceptance edge. A same-edge
  // backdoor write to the word being read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
    if (accept) begin
      word_q <= mem[rd_idx];
    end
  end

  // Next-state logic for the data-phase sequencer.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle, StLast: begin
        if (accept) begin
          wait_cnt_d = wait_cfg;
          state_d    = (wait_cfg == '0) ? StLast : StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (wait_cnt_q == W_WAIT'(1)) begin
          state_d    = StLast;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - W_WAIT'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, handshake outputs and completion counter, all registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      mem_addr_rdy <= 1'b1;
      mem_data_vld <= 1'b0;
      busy         <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_addr_rdy <= (state_d == StIdle) || (state_d == StLast);
      mem_data_vld <= (state_d == StLast);
      busy         <= (state_d != StIdle);
      if (mem_data_vld) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  // Data bus is forced to zero outside the completing cycle.
  assign mem_data = mem_data_vld ? word_q : '0;

endmodule

// File: tb/tb_hazard5_fetch_responder.sv
// Bench for hazard5_fetch_responder: directed steps plus random streams,
// checked every cycle against a transaction-queue reference model.
module tb_hazard5_fetch_responder;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned W_IDX     = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_size;
  logic [31:0]       mem_addr;
  logic              mem_addr_vld;
  logic              mem_addr_rdy;
  logic [31:0]       mem_data;
  logic              mem_data_vld;
  logic [1:0]        wait_cfg;
  logic              ld_en;
  logic [W_IDX-1:0]  ld_addr;
  logic [31:0]       ld_data;
  logic [31:0]       fetch_count;
  logic              busy;

  always #5 clk = ~clk;

  hazard5_fetch_responder #(
    .W_ADDR   (32),
    .W_DATA   (32),
    .MEM_DEPTH(MEM_DEPTH),
    .W_WAIT   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_addr_vld(mem_addr_vld),
    .mem_addr_rdy(mem_addr_rdy),
    .mem_data    (mem_data),
    .mem_data_vld(mem_data_vld),
    .wait_cfg    (wait_cfg),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .fetch_count (fetch_count),
    .busy        (busy)
  );

  // Reference model: each accepted fetch is a queue entry holding the word it
  // must return and the absolute cycle on which it must complete.
  typedef struct {
    logic [31:0] word;
    int unsigned due;
  } txn_t;

  txn_t        pend[$];
  logic [31:0] ref_mem [MEM_DEPTH];
  int unsigned now = 0;
  logic [31:0] exp_count = 32'h0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          check_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input logic vld, input logic [31:0] addr, input logic sz,
                       input logic [1:0] w, input logic le, input logic [W_IDX-1:0] la,
                       input logic [31:0] ld, output bit acc);
    logic        exp_vld;
    logic        exp_rdy;
    logic [31:0] exp_data;
    txn_t        t;
    mem_addr_vld = vld;
    mem_addr     = addr;
    mem_size     = sz;
    wait_cfg     = w;
    ld_en        = le;
    ld_addr      = la;
    ld_data      = ld;
    if (vld && addr[0]) $display("note: odd fetch address %h has undefined behaviour", addr);
    @(negedge clk);
    exp_vld  = (pend.size() > 0) && (pend[0].due == now);
    exp_rdy  = (pend.size() == 0) || exp_vld;
    exp_data = exp_vld ? pend[0].word : 32'h0;
    if (check_en) begin
      chk("addr_rdy", {31'h0, mem_addr_rdy}, {31'h0, exp_rdy});
      chk("data_vld", {31'h0, mem_data_vld}, {31'h0, exp_vld});
      chk("data", mem_data, exp_data);
      chk("busy", {31'h0, busy}, {31'h0, pend.size() > 0});
      chk("fetch_count", fetch_count, exp_count);
    end
    acc = rst_n && vld && exp_rdy;
    if (exp_vld) begin
      void'(pend.pop_front());
      exp_count = exp_count + 32'd1;
    end
    if (acc) begin
      t.word = ref_mem[addr[2 +: W_IDX]];
      t.due  = now + 1 + int'(w);
      pend.push_back(t);
    end
    if (le) ref_mem[la] = ld;
    if (!rst_n) begin
      pend.delete();
      exp_count = 32'h0;
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, '0, 32'h0, acc);
  endtask

  task automatic load(input logic [W_IDX-1:0] idx, input logic [31:0] d);
    bit acc;
    cycle(1'b0, 32'h0, 1'b1, 2'd0, 1'b1, idx, d, acc);
  endtask

  // Present a request and hold it stable until accepted (bounded).
  task automatic fetch(input logic [31:0] addr, input logic sz, input logic [1:0] w);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 16) begin
      cycle(1'b1, addr, sz, w, 1'b0, '0, 32'h0, acc);
      tries++;
    end
    n_cmp++;
    if (!acc) begin
      n_fail++;
      $error("FAIL accept_timeout: observed not accepted expected accepted (addr %h)", addr);
    end
  endtask

  task automatic rand_fetch(input bit allow_half);
    logic [31:0] r;
    logic [31:0] a;
    logic        sz;
    r  = $urandom;
    a  = {r[31:12], 4'h0, r[7:2], 2'b00};
    sz = 1'b1;
    if (allow_half && r[8]) begin
      sz   = 1'b0;
      a[1] = r[9];
    end
    if (r[10]) idle(int'($urandom_range(1, 2)));
    fetch(a, sz, 2'($urandom_range(0, 3)));
  endtask

  initial begin
    bit          acc;
    logic [31:0] newv;
    rst_n        = 1'b0;
    mem_size     = 1'b1;
    mem_addr     = 32'h0;
    mem_addr_vld = 1'b0;
    wait_cfg     = 2'd0;
    ld_en        = 1'b0;
    ld_addr      = '0;
    ld_data      = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Program image: random fill of the low 64 words, then the known pair.
    for (int i = 0; i < 64; i++) load(W_IDX'(i), $urandom);
    load(10'd0, 32'h0000_0013);
    load(10'd1, 32'h0010_0093);

    // Back-to-back zero-wait fetches.
    cycle(1'b1, 32'h0, 1'b1, 2'd0, 1'b0, '0, 32'h0, acc);
    cycle(1'b1, 32'h4, 1'b1, 2'd0, 1'b0, '0, 32'h0, acc);
    idle(3);
    chk("b2b_fetch_count", fetch_count, 32'd2);

    // Single fetch with two wait states.
    fetch(32'h4, 1'b1, 2'd2);
    idle(4);

    // Short random stream.
    for (int k = 0; k < 8; k++) rand_fetch(1'b0);
    idle(5);

    // Halfword access to the upper half of word 1.
    fetch(32'h6, 1'b0, 2'd1);
    idle(3);

    // Address wraps modulo RAM size.
    fetch(32'h1000, 1'b1, 2'd0);
    idle(2);

    // Backdoor write colliding with the read on the acceptance cycle.
    newv = ~ref_mem[5];
    cycle(1'b1, 32'h14, 1'b1, 2'd0, 1'b1, 10'd5, newv, acc);
    n_cmp++;
    if (!acc) begin
      n_fail++;
      $error("FAIL collide_accept: observed not accepted expected accepted");
    end
    idle(2);
    fetch(32'h14, 1'b1, 2'd1);
    idle(3);

    // Reset asserted while a three-wait-state phase is in progress.
    cycle(1'b1, 32'h8, 1'b1, 2'd3, 1'b0, '0, 32'h0, acc);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    chk("post_reset_count", fetch_count, 32'd0);
    idle(2);
    fetch(32'h4, 1'b1, 2'd0);
    idle(3);

    // Longer random stream including halfwords and high address bits.
    for (int k = 0; k < 150; k++) rand_fetch(1'b1);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard5_fetch_responder.md
Name: hazard5_fetch_responder

Overview:
- Slave end of the instruction-fetch memory interface: accepts fetch address phases from the core frontend and returns instruction words from an internal synchronous RAM.
- Address and data phases are AHB-style pipelined; runtime-programmable wait states exercise frontend stall paths.
- Used as tightly coupled boot/instruction memory in small configurations and as the standard fetch-side bench model.
- A backdoor write port loads the program image.

Parameters:
- W_ADDR, 32, address width; only 32 is supported.
- W_DATA, 32, data width; only 32 is supported.
- MEM_DEPTH, 1024, RAM depth in 32-bit words; must be a power of 2.
- W_WAIT, 2, width of the wait-state configuration input.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- mem_size  input  1  1 = 32-bit access, 0 = 16-bit access
- mem_addr  input  W_ADDR  fetch byte address
- mem_addr_vld  input  1  address phase request
- mem_addr_rdy  output  1  address phase accepted this cycle when high with vld
- mem_data  output  W_DATA  fetch data
- mem_data_vld  output  1  data phase completes this cycle
- wait_cfg  input  W_WAIT  extra data-phase cycles, sampled at address acceptance
- ld_en  input  1  backdoor write strobe
- ld_addr  input  $clog2(MEM_DEPTH)  backdoor word index
- ld_data  input  W_DATA  backdoor write data
- fetch_count  output  32  completed data phases since reset
- busy  output  1  data phase in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: mem_addr_rdy=1, mem_data_vld=0, mem_data=0, busy=0, fetch_count=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Reset asserted mid-data-phase: the phase is abandoned and the next cycle is IDLE with no mem_data_vld.
- Acceptance: an address is accepted on a cycle where mem_addr_vld && mem_addr_rdy.
  - The RAM read is issued that cycle using index mem_addr[2 +: $clog2(MEM_DEPTH)]; upper bits are ignored, so addresses wrap modulo the RAM size.
  - wait_cfg is latched into the wait counter.
- mem_addr_rdy = (FSM==IDLE) || (FSM==LAST). It is a pure function of registered state, and never of mem_addr_vld.
- FSM states:
  - IDLE: no data phase in progress.
    - Accept with latched wait=0 → LAST.
    - Accept with wait>0 → WAIT.
    - Otherwise stay IDLE.
  - WAIT: mem_data_vld=0, mem_addr_rdy=0, counter decrements each cycle. Go to LAST when the counter reaches 1 this cycle.
  - LAST: mem_data_vld=1, mem_data=captured word.
    - A new acceptance in the same cycle (back-to-back) → LAST or WAIT per the new wait_cfg.
    - Otherwise → IDLE.
- Latency: data valid 1+wait_cfg cycles after acceptance. At most 2 transactions are outstanding: one in the data phase and one being accepted.
- Zero-wait streaming sustains 1 word/cycle.
- Read data: the RAM output is captured in a data register on the first data-phase cycle and held through WAIT. mem_data is 0 whenever mem_data_vld=0.
- Halfword access (mem_size=0): the full aligned word is returned. mem_addr[1] does not alter data lanes; the initiator selects the half.
  - mem_size=0 with mem_addr[1]=0 is legal.
  - mem_addr[0]=1 is unsupported; behaviour is undefined and the bench flags it.
- Jump during wait: the initiator keeps addr/vld stable while rdy is low. The responder ignores address changes outside acceptance cycles and always completes in-flight phases. Discarding flushed data is the initiator's job.
- Backdoor collision: ld_en writing the word being read on the acceptance cycle returns the pre-write data. The write completes, and later reads see the new value.
- fetch_count increments on each mem_data_vld cycle and wraps at 2^32.
- busy = (FSM != IDLE).

Test Plan:
- Load words 0x00000013 at index 0 and 0x00100093 at index 1. Fetch 0x0 then 0x4 back-to-back with wait_cfg=0 → rdy held high; data_vld on cycles 1 and 2; data 0x00000013 then 0x00100093; fetch_count=2.
- wait_cfg=2, single fetch of 0x4 → rdy low for 2 cycles; data_vld 3 cycles after acceptance with data 0x00100093; rdy high on the data_vld cycle.
- Stream 8 fetches with random wait_cfg 0..3 → data returned in order; never more than 2 outstanding; mem_data=0 whenever data_vld=0.
- mem_size=0 at address 0x6 → returns full word at index 1 (0x00100093) after the programmed latency.
- Address 0x1000 with MEM_DEPTH=1024 → returns word at index 0. Fetch of index 5 coinciding with ld_en to index 5 → old value returned, then the new value on the next fetch.
- rst_n low during a WAIT phase with wait_cfg=3 → next cycle mem_data_vld=0, rdy=1, busy=0, fetch_count=0.
